// File: rtl/core_pkg.sv
// Shared types and constants for the rv32 core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  HALT_NONE     = 2'd0;
    localparam logic [1:0]  HALT_SYSTEM   = 2'd1;
    localparam logic [1:0]  HALT_MISALIGN = 2'd2;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    function automatic logic is_system(input logic [31:0] insn);
        return insn[6:0] == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/core_fetch_instret_counter.sv
// Retired-instruction counter: wide free-running counter with increment enable.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; wraps silently at all-ones.
module instret_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/core_fetch.sv
// Instruction sequencer: fetches over req/rvalid, strobes active once per instruction.
// Latency: 2 cycles per instruction minimum, +1 per memory wait cycle.
// Backpressure: stall blocks new requests only; outstanding requests run to completion.
module core_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        active,
    output logic [31:0] pc,
    output logic [31:0] ir,
    input  logic [31:0] nextpc,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [63:0] instret
);

    fetch_state_t state;

    // The request address is the architectural PC; pc only moves while no request is out.
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            imem_req   <= 1'b0;
            pc         <= RESET_PC;
            ir         <= NOP_INSN;
            active     <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= HALT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stall) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_rvalid) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        if (is_system(imem_rdata)) begin
                            state      <= ST_HALT;
                            halted     <= 1'b1;
                            halt_cause <= HALT_SYSTEM;
                        end else begin
                            state  <= ST_EXEC;
                            active <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    active <= 1'b0;
                    // A misaligned target halts with pc still naming the faulting instruction.
                    if (nextpc[1:0] != 2'b00) begin
                        state      <= ST_HALT;
                        halted     <= 1'b1;
                        halt_cause <= HALT_MISALIGN;
                    end else begin
                        pc <= nextpc;
                        if (!stall) begin
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    imem_req <= 1'b0;
                    active   <= 1'b0;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    // The instruction retires in its EXEC cycle, whatever happens to nextpc.
    instret_counter #(.W(64)) u_instret (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (state == ST_EXEC),
        .count (instret)
    );

endmodule

// File: tb/tb_core_fetch.sv
// Randomized bench for core_fetch with a transaction-level reference model.
module tb_core_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        active;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] nextpc;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural reference state, updated once per instruction.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [63:0] m_instret;
    logic        m_halted;
    logic [1:0]  m_cause;

    int cyc = 0;
    int active_t[$];

    core_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .active      (active),
        .pc          (pc),
        .ir          (ir),
        .nextpc      (nextpc),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instret     (instret)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst_n === 1'b1 && active === 1'b1) active_t.push_back(cyc);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'b1110011) w[6:0] = 7'b0010011;
        return w;
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_ir      = NOP_W;
        m_instret = 64'd0;
        m_halted  = 1'b0;
        m_cause   = 2'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},     imem_req,   0);
        check({tag, "_addr"},    imem_addr,  RST_PC);
        check({tag, "_pc"},      pc,         RST_PC);
        check({tag, "_ir"},      ir,         NOP_W);
        check({tag, "_active"},  active,     0);
        check({tag, "_halted"},  halted,     0);
        check({tag, "_cause"},   halt_cause, 0);
        check({tag, "_instret"}, instret,    0);
    endtask

    // Holds reset for two cycles, checks reset values, releases with stall low.
    task automatic do_reset(input string tag);
        rst_n = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; nextpc = '0;
        model_reset();
        tick(); tick();
        check_reset_state(tag);
        rst_n = 1'b1;
        tick();
        check({tag, "_first_req"},  imem_req,  1);
        check({tag, "_first_addr"}, imem_addr, RST_PC);
    endtask

    // Entered and left at a negedge with imem_req visible (unless the instruction halts).
    task automatic run_insn(input int wt, input logic [31:0] insn, input logic [31:0] npc,
                            input logic stall_exec, input logic stray, input int idle_cyc);
        for (int i = 0; i < wt; i++) begin
            check("wait_req",    imem_req,  1);
            check("wait_addr",   imem_addr, m_pc);
            check("wait_active", active,    0);
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        check("rv_req",  imem_req,  1);
        check("rv_addr", imem_addr, m_pc);
        imem_rvalid = 1'b1;
        imem_rdata  = insn;
        stall       = 1'($urandom_range(0, 1));
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        m_ir        = insn;
        if (insn[6:0] == 7'b1110011) begin
            m_halted = 1'b1;
            m_cause  = 2'd1;
            check("sys_halted",  halted,     m_halted);
            check("sys_cause",   halt_cause, m_cause);
            check("sys_active",  active,     0);
            check("sys_req",     imem_req,   0);
            check("sys_instret", instret,    m_instret);
            check("sys_ir",      ir,         m_ir);
            return;
        end
        check("exec_active", active,   1);
        check("exec_pc",     pc,       m_pc);
        check("exec_ir",     ir,       m_ir);
        check("exec_req",    imem_req, 0);
        check("exec_halted", halted,   0);
        nextpc = npc;
        stall  = stall_exec;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~insn;
        end
        tick();
        imem_rvalid = 1'b0;
        nextpc      = $urandom;
        m_instret   = m_instret + 64'd1;
        check("post_active",  active,  0);
        check("post_instret", instret, m_instret);
        check("post_ir",      ir,      m_ir);
        if (npc[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_cause  = 2'd2;
            check("mis_halted", halted,     m_halted);
            check("mis_cause",  halt_cause, m_cause);
            check("mis_pc",     pc,         m_pc);
            check("mis_req",    imem_req,   0);
            return;
        end
        m_pc = npc;
        check("post_pc",     pc,     m_pc);
        check("post_halted", halted, 0);
        if (!stall_exec) begin
            check("next_req", imem_req, 1);
            return;
        end
        check("idle_req", imem_req, 0);
        for (int i = 0; i < idle_cyc; i++) begin
            imem_rvalid = (i == 0);
            imem_rdata  = $urandom;
            stall       = 1'b1;
            tick();
            imem_rvalid = 1'b0;
            check("idle_req_hold", imem_req, 0);
            check("idle_active",   active,   0);
            check("idle_ir",       ir,       m_ir);
        end
        stall = 1'b0;
        tick();
        check("refetch_req",  imem_req,  1);
        check("refetch_addr", imem_addr, m_pc);
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            stall       = 1'($urandom_range(0, 1));
            tick();
            check("halt_halted",  halted,     1);
            check("halt_cause",   halt_cause, m_cause);
            check("halt_active",  active,     0);
            check("halt_req",     imem_req,   0);
            check("halt_instret", instret,    m_instret);
            check("halt_pc",      pc,         m_pc);
            check("halt_ir",      ir,         m_ir);
        end
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; nextpc = '0;
        model_reset();
        tick();
        do_reset("rst0");

        // Zero-wait memory: one instruction every 2 cycles.
        active_t.delete();
        for (int k = 0; k < 5; k++) run_insn(0, rand_insn(), m_pc + 32'd4, 1'b0, 1'b0, 0);
        check("seq_pc",      pc,      32'h114);
        check("seq_instret", instret, 64'd5);
        check("seq_active_count", 64'(active_t.size()), 64'd5);
        for (int k = 1; k < active_t.size(); k++)
            check("seq_active_period", 64'(active_t[k] - active_t[k-1]), 64'd2);

        // Three wait cycles: 5 cycles per instruction.
        active_t.delete();
        for (int k = 0; k < 3; k++) run_insn(3, rand_insn(), m_pc + 32'd4, 1'b0, 1'b0, 0);
        check("w3_active_count", 64'(active_t.size()), 64'd3);
        for (int k = 1; k < active_t.size(); k++)
            check("w3_active_period", 64'(active_t[k] - active_t[k-1]), 64'd5);

        // Random latency, targets, stalls and stray rvalid pulses.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] npc;
            npc = $urandom;
            npc[1:0] = 2'b00;
            run_insn($urandom_range(0, 3), rand_insn(), npc,
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 3));
        end
        check("rand_instret", instret, m_instret);

        // Reset in the middle of a fetch abandons the request; a late rvalid is ignored.
        tick();
        rst_n = 1'b0;
        stall = 1'b1;
        #1;
        check("midrst_req", imem_req, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle_req", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("late_rvalid_ir",     ir,     NOP_W);
        check("late_rvalid_active", active, 0);
        stall = 1'b0;
        tick();
        check("midrst_refetch_req",  imem_req,  1);
        check("midrst_refetch_addr", imem_addr, RST_PC);

        // Misaligned target at pc 0x200.
        run_insn(0, rand_insn(), 32'h200, 1'b0, 1'b0, 0);
        run_insn(1, rand_insn(), 32'h202, 1'b0, 1'b0, 0);
        check("mis_final_pc",      pc,      32'h200);
        check("mis_final_instret", instret, 64'd2);
        hold_halt(5);
        do_reset("rst1");

        // EBREAK halts without retiring.
        run_insn(0, rand_insn(), 32'h104, 1'b0, 1'b0, 0);
        run_insn(2, 32'h0010_0073, 32'h0, 1'b0, 1'b0, 0);
        check("ebreak_instret", instret, 64'd1);
        active_t.delete();
        hold_halt(20);
        check("ebreak_no_active", 64'(active_t.size()), 64'd0);
        do_reset("rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction sequencer for the rv32 core. It fetches each instruction from instruction memory over a request/valid handshake, holds `pc`/`ir` stable for the combinational execute stage (`core_ctrl`) and pulses `active` for exactly one cycle per instruction. It then commits `nextpc`, counts retired instructions, and halts on SYSTEM opcodes or a misaligned target PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: when high, no new fetch request is started.
- `imem_req`  out  1: fetch request, held until `imem_rvalid`.
- `imem_addr`  out  32: fetch address, equals `pc`, stable while `imem_req`.
- `imem_rvalid`  in  1: fetch data valid, single-cycle pulse.
- `imem_rdata`  in  32: instruction word, sampled when `imem_rvalid`.
- `active`  out  1: execute strobe to `core_ctrl`.
- `pc`  out  32: PC of the current instruction.
- `ir`  out  32: current instruction word.
- `nextpc`  in  32: next PC from `core_ctrl`, sampled in EXEC.
- `halted`  out  1: sticky halt flag.
- `halt_cause`  out  2: 0 none, 1 SYSTEM opcode, 2 misaligned nextpc.
- `instret`  out  64: retired-instruction counter.

## Operation
- The design has 4 states: IDLE, FETCH, EXEC and HALT. All outputs are registered.
- Reset values: state IDLE, `imem_req`=0, `pc`=`imem_addr`=RESET_PC, `ir`=32'h0000_0013 (NOP), `active`=0, `halted`=0, `halt_cause`=0, `instret`=0.
- IDLE:
  - If `stall`=0, go to FETCH with `imem_req`=1.
  - Otherwise remain in IDLE.
- FETCH: hold `imem_req`=1 and `imem_addr`=`pc` until `imem_rvalid`. On `imem_rvalid`:
  - Latch `ir`<=`imem_rdata` and drop `imem_req`.
  - If `imem_rdata[6:0]`=7'b1110011, go to HALT with `halt_cause`=1. `active` is never raised and `instret` is unchanged.
  - Otherwise go to EXEC.
- EXEC: `active`=1 for this one cycle. At the end of the cycle:
  - `instret`<=`instret`+1, since the instruction's register and memory writes occur this cycle.
  - If `nextpc[1:0]`!=0: go to HALT with `halt_cause`=2 and leave `pc` at the faulting instruction.
  - Otherwise `pc`<=`nextpc`. Go to FETCH (`imem_req`=1) if `stall`=0, else go to IDLE.
- HALT: `halted`=1, `active`=0, `imem_req`=0. The state is sticky until `rst_n` is asserted.
- `stall` only gates the start of a request. An outstanding request is never withdrawn because of `stall`.
- `imem_rvalid` outside FETCH is ignored; it neither changes `ir` nor raises an error.
- `instret` wraps from 2^64−1 to 0 with no flag.
- Reset mid-fetch abandons the request. Instruction memory must tolerate a dropped request and any late `imem_rvalid` is ignored.

## Timing
- First request: `imem_req` rises in the first clock edge after `rst_n` deasserts, provided `stall`=0.
- Minimum throughput: 2 cycles per instruction, when `imem_rvalid` arrives in the same cycle that `imem_req` is first visible.
- Each extra memory-wait cycle adds 1 cycle per instruction.
- `active` rises 1 cycle after the `imem_rvalid` cycle and is never high for 2 consecutive cycles.
- `pc` and `ir` are stable through the whole EXEC cycle. `nextpc` is sampled only at the EXEC-cycle edge.
- `imem_addr` changes only when `imem_req`=0.
- `halted` and `halt_cause` update at the same edge as the transition into HALT.

## Structure
- Shared package `core_pkg`:
  - state encoding (IDLE/FETCH/EXEC/HALT);
  - halt_cause constants (HALT_NONE/HALT_SYSTEM/HALT_MISALIGN);
  - OPC_SYSTEM = 7'b1110011;
  - NOP_INSN = 32'h0000_0013.
- One sub-module, `instret_counter`: 64-bit counter with increment enable and async active-low clear.

## Test plan
- Reset with RESET_PC=32'h100 and a memory that returns `imem_rvalid` 0 wait cycles after each request:
  - first `imem_addr`=32'h100;
  - `active` high once every 2 cycles;
  - with `nextpc`=`pc`+4, after 5 instructions `pc`=32'h114 and `instret`=5.
- Memory with 3 wait cycles: `imem_req` and `imem_addr` stay constant for 4 cycles, then `active` pulses one cycle later; total 5 cycles per instruction.
- A stray `imem_rvalid` pulse during EXEC and during IDLE: `ir` is unchanged and no extra `active` pulse occurs.
- `stall`=1 asserted during EXEC: the state goes to IDLE with `imem_req` low. `stall`=1 asserted mid-FETCH: the request is held until `imem_rvalid`.
- Fetch returns 32'h0010_0073 (EBREAK): `halted`=1, `halt_cause`=1, no `active` pulse, `instret` unchanged, and the state stays in HALT for 20 cycles.
- `nextpc`=32'h202 in EXEC at `pc`=32'h200: `halted`=1, `halt_cause`=2, `pc`=32'h200, `instret` incremented. A later `rst_n` pulse restores all reset values.
